// File: rtl/dcache_pkg.sv
// Shared defaults and types for the data-cache tag/data store.
package dcache_pkg;
  localparam int DCACHE_SETS   = 16;
  localparam int DCACHE_WAYS   = 2;
  localparam int DCACHE_TAG_W  = 23;
  localparam int DCACHE_LINE_W = 256;
  localparam int DCACHE_CNT_W  = 32;

  typedef logic [DCACHE_LINE_W-1:0] line_t;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DCACHE_TAG_W-1:0] tag;
  } way_meta_t;
endpackage

// File: rtl/dcache_sram_nway_if.sv
// Request/response bundle between the dcache controller (master) and the tag/data store (slave).
interface dcache_sram_nway_if
  import dcache_pkg::*;
#(
  parameter int IDX_W  = $clog2(DCACHE_SETS),
  parameter int WAY_W  = $clog2(DCACHE_WAYS),
  parameter int TAG_W  = DCACHE_TAG_W,
  parameter int LINE_W = DCACHE_LINE_W,
  parameter int CNT_W  = DCACHE_CNT_W
) ();
  logic              req_i;
  logic              wr_i;
  logic [IDX_W-1:0]  idx_i;
  logic [TAG_W-1:0]  tag_i;
  logic [WAY_W-1:0]  way_i;
  logic [LINE_W-1:0] wdata_i;
  logic              wdirty_i;
  logic              rsp_valid_o;
  logic              hit_o;
  logic [WAY_W-1:0]  hit_way_o;
  logic [LINE_W-1:0] rdata_o;
  logic [WAY_W-1:0]  victim_way_o;
  logic              victim_valid_o;
  logic              victim_dirty_o;
  logic [TAG_W-1:0]  victim_tag_o;
  logic [LINE_W-1:0] victim_data_o;
  logic [CNT_W-1:0]  hit_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  modport master (
    output req_i, wr_i, idx_i, tag_i, way_i, wdata_i, wdirty_i,
    input  rsp_valid_o, hit_o, hit_way_o, rdata_o, victim_way_o, victim_valid_o,
           victim_dirty_o, victim_tag_o, victim_data_o, hit_cnt_o, miss_cnt_o
  );

  modport slave (
    input  req_i, wr_i, idx_i, tag_i, way_i, wdata_i, wdirty_i,
    output rsp_valid_o, hit_o, hit_way_o, rdata_o, victim_way_o, victim_valid_o,
           victim_dirty_o, victim_tag_o, victim_data_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/dcache_lru.sv
// True-LRU age update and victim pick for one set; purely combinational.
module dcache_lru #(
  parameter int WAYS  = 2,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]           touch_way_i,
  output logic [WAYS-1:0][WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]           victim_way_o
);
  localparam logic [WAY_W-1:0] AGE_ONE = 1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  always_comb begin
    age_o = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] < age_i[touch_way_i]) age_o[w] = age_i[w] + AGE_ONE;
    end
    age_o[touch_way_i] = '0;
  end

  // Oldest way by default; any invalid way overrides, lowest index last so it wins.
  always_comb begin
    victim_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == AGE_MAX) victim_way_o = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_way_o = WAY_W'(w);
    end
  end
endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative tag/data store with true-LRU and registered lookups.
// Optional statistics counters are built when DCACHE_SRAM_STATS_EN is defined.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int SETS   = DCACHE_SETS,
  parameter int WAYS   = DCACHE_WAYS,
  parameter int TAG_W  = DCACHE_TAG_W,
  parameter int LINE_W = DCACHE_LINE_W,
  parameter int CNT_W  = DCACHE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_sram_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("dcache_sram_nway: SETS must be a power of 2 and at least 2");
  end
  if (WAYS < 2 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("dcache_sram_nway: WAYS must be a power of 2 in 2..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("dcache_sram_nway: CNT_W must be at least 1");
  end

  logic [TAG_W-1:0]            tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]           data_mem [SETS][WAYS];
  logic [WAYS-1:0]             valid_q  [SETS];
  logic [WAYS-1:0]             dirty_q  [SETS];
  logic [WAYS-1:0][WAY_W-1:0]  age_q    [SETS];

  logic [IDX_W-1:0]            idx;
  logic                        lookup, write, lk_hit, age_upd;
  logic [WAY_W-1:0]            lk_way, touch_way, vic_way;
  logic [WAYS-1:0][WAY_W-1:0]  age_set_d;

  logic              rsp_valid_q, rsp_valid_d, hit_q, hit_d;
  logic [WAY_W-1:0]  hit_way_q, hit_way_d, victim_way_q, victim_way_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, victim_data_q, victim_data_d;
  logic              victim_valid_q, victim_valid_d, victim_dirty_q, victim_dirty_d;
  logic [TAG_W-1:0]  victim_tag_q, victim_tag_d;

  // A request coinciding with reset is dropped entirely.
  assign idx       = bus.idx_i;
  assign lookup    = bus.req_i & ~bus.wr_i & ~rst_i;
  assign write     = bus.req_i &  bus.wr_i & ~rst_i;
  assign touch_way = write ? bus.way_i : lk_way;
  assign age_upd   = write | (lookup & lk_hit);

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_mem[idx][w] == bus.tag_i) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  dcache_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .age_i        (age_q[idx]),
    .valid_i      (valid_q[idx]),
    .touch_way_i  (touch_way),
    .age_o        (age_set_d),
    .victim_way_o (vic_way)
  );

  always_comb begin
    rsp_valid_d    = lookup;
    hit_d          = hit_q;
    hit_way_d      = hit_way_q;
    rdata_d        = rdata_q;
    victim_way_d   = victim_way_q;
    victim_valid_d = victim_valid_q;
    victim_dirty_d = victim_dirty_q;
    victim_tag_d   = victim_tag_q;
    victim_data_d  = victim_data_q;
    if (lookup) begin
      hit_d          = lk_hit;
      hit_way_d      = lk_way;
      rdata_d        = data_mem[idx][lk_way];
      victim_way_d   = vic_way;
      victim_valid_d = valid_q[idx][vic_way];
      victim_dirty_d = dirty_q[idx][vic_way];
      victim_tag_d   = tag_mem[idx][vic_way];
      victim_data_d  = data_mem[idx][vic_way];
    end
  end

  always_ff @(posedge clk_i) begin
    if (write) begin
      tag_mem[idx][bus.way_i]  <= bus.tag_i;
      data_mem[idx][bus.way_i] <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
      rsp_valid_q    <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      rdata_q        <= '0;
      victim_way_q   <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
      victim_data_q  <= '0;
    end else begin
      if (write) begin
        valid_q[idx][bus.way_i] <= 1'b1;
        dirty_q[idx][bus.way_i] <= bus.wdirty_i;
      end
      if (age_upd) age_q[idx] <= age_set_d;
      rsp_valid_q    <= rsp_valid_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      rdata_q        <= rdata_d;
      victim_way_q   <= victim_way_d;
      victim_valid_q <= victim_valid_d;
      victim_dirty_q <= victim_dirty_d;
      victim_tag_q   <= victim_tag_d;
      victim_data_q  <= victim_data_d;
    end
  end

`ifdef DCACHE_SRAM_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup && lk_hit && hit_cnt_q != '1)    hit_cnt_d  = hit_cnt_q + CNT_ONE;
    if (lookup && !lk_hit && miss_cnt_q != '1)  miss_cnt_d = miss_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
`else
  assign bus.hit_cnt_o  = '0;
  assign bus.miss_cnt_o = '0;
`endif

  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.hit_o          = hit_q;
  assign bus.hit_way_o      = hit_way_q;
  assign bus.rdata_o        = rdata_q;
  assign bus.victim_way_o   = victim_way_q;
  assign bus.victim_valid_o = victim_valid_q;
  assign bus.victim_dirty_o = victim_dirty_q;
  assign bus.victim_tag_o   = victim_tag_q;
  assign bus.victim_data_o  = victim_data_q;
endmodule
